// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read-side signals plus the valid/ready output stream
//   fifo_empty / fifo_q / fifo_rdreq : link to a SHOWAHEAD="OFF" FIFO (q valid one cycle after rdreq)
//   data / valid / ready             : output stream
//   buf_used                         : output buffer occupancy 0..3
interface fifo_stream_reader_if #(
    parameter int DWIDTH = 8
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_q;
    logic              fifo_rdreq;
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic [1:0]        buf_used;
    modport slave (
        input  fifo_empty, fifo_q, ready,
        output fifo_rdreq, data, valid, buf_used
    );
    modport master (
        output fifo_empty, fifo_q, ready,
        input  fifo_rdreq, data, valid, buf_used
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a 1-cycle-latency FIFO read port into a valid/ready stream
//   clk_i  : clock, rising edge
//   srst_i : synchronous active-high reset, shared with the FIFO
//   bus    : slave side of fifo_stream_reader_if (FIFO read link, stream out, occupancy)
module fifo_stream_reader #(
    parameter int DWIDTH    = 8,
    parameter int BUF_DEPTH = 3
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    fifo_stream_reader_if.slave  bus
);
    localparam logic [1:0] LAST = 2'(BUF_DEPTH - 1);
    logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
    logic [1:0]        cnt_q, cnt_d, rd_q, rd_d, wr_q, wr_d;
    logic              inflight_q, pop, rdreq;
    // Counting the in-flight word as occupied guarantees a slot for it at capture time,
    // so ready_i never has to reach rdreq.
    assign rdreq = !bus.fifo_empty && !srst_i && (({1'b0, cnt_q} + {2'b0, inflight_q}) < 3'(BUF_DEPTH));
    assign pop   = bus.valid && bus.ready;
    always_comb begin
        cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        wr_d  = !inflight_q ? wr_q : (wr_q == LAST) ? 2'd0 : wr_q + 2'd1;
        rd_d  = !pop ? rd_q : (rd_q == LAST) ? 2'd0 : rd_q + 2'd1;
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            inflight_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            inflight_q <= rdreq;
            if (inflight_q) mem_q[wr_q] <= bus.fifo_q;
        end
    end
    assign bus.fifo_rdreq = rdreq;
    assign bus.valid      = cnt_q != 2'd0;
    assign bus.data       = mem_q[rd_q];
    assign bus.buf_used   = cnt_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of fifo_stream_reader against a behavioural SHOWAHEAD="OFF" FIFO
module tb_fifo_stream_reader;
    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fq[$];
    logic [7:0] got[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         rd_cnt = 0;
    logic       hold_q = 1'b0;
    logic [7:0] hold_d = 8'h00;
    fifo_stream_reader_if #(.DWIDTH(8)) bus ();
    fifo_stream_reader #(.DWIDTH(8), .BUF_DEPTH(3)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_q     = 8'h00;
    end
    always @(posedge clk) begin
        if (srst) begin
            fq.delete();
            bus.fifo_q     <= 8'h00;
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_rdreq && fq.size() != 0) bus.fifo_q <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            bus.fifo_empty <= (fq.size() == 0);
        end
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask
    always @(negedge clk) begin
        if (srst) begin
            hold_q = 1'b0;
        end else begin
            check("no_underflow", {31'b0, bus.fifo_rdreq & bus.fifo_empty}, 0);
            if (bus.fifo_rdreq) rd_cnt++;
            if (hold_q) begin
                check("hold_valid", {31'b0, bus.valid}, 1);
                check("hold_data", {24'b0, bus.data}, {24'b0, hold_d});
            end
            hold_q = bus.valid && !bus.ready;
            hold_d = bus.data;
            if (bus.valid && bus.ready) got.push_back(bus.data);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic cmp_words(input string tag, input int base, input logic [7:0] exp[$]);
        check({tag, "_count"}, got.size() - base, exp.size());
        for (int i = 0; i < exp.size() && base + i < got.size(); i++)
            check({tag, "_word"}, {24'b0, got[base + i]}, {24'b0, exp[i]});
    endtask
    initial begin
        logic [7:0]  exp[$];
        logic [7:0]  t1[4];
        logic [11:0] vv, rv;
        logic [7:0]  w;
        int          base, rd_base, nv;
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.ready = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'b0, bus.valid}, 0);
        check("rst_data", {24'b0, bus.data}, 0);
        check("rst_used", {30'b0, bus.buf_used}, 0);
        check("rst_rdreq", {31'b0, bus.fifo_rdreq}, 0);
        srst = 1'b0;
        tick();
        // four words, always ready
        base = got.size();
        vv = '0;
        rv = '0;
        for (int c = 0; c < 8; c++) begin
            wr_en   = c < 4;
            wr_data = (c < 4) ? t1[c] : 8'h00;
            rv[c]   = bus.fifo_rdreq;
            vv[c]   = bus.valid;
            tick();
        end
        wr_en = 1'b0;
        check("t1_rdreq_cycles", {20'b0, rv}, 32'h01E);
        check("t1_valid_cycles", {20'b0, vv}, 32'h078);
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        cmp_words("t1", base, exp);
        // ten words under backpressure
        bus.ready = 1'b0;
        base = got.size();
        rd_base = rd_cnt;
        exp.delete();
        w = 8'h80;
        for (int c = 0; c < 10; c++) begin
            wr_en = 1'b1;
            wr_data = w;
            exp.push_back(w);
            w++;
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("t2_rdreq_pulses", rd_cnt - rd_base, 3);
        check("t2_used", {30'b0, bus.buf_used}, 3);
        check("t2_fifo_usedw", fq.size(), 7);
        check("t2_valid", {31'b0, bus.valid}, 1);
        check("t2_data", {24'b0, bus.data}, 32'h80);
        tick();
        tick();
        check("t2_data_held", {24'b0, bus.data}, 32'h80);
        bus.ready = 1'b1;
        vv = '0;
        for (int c = 0; c < 12; c++) begin
            vv[c] = bus.valid;
            tick();
        end
        check("t2_stream_cycles", {20'b0, vv}, 32'h3FF);
        cmp_words("t2", base, exp);
        // random data, random ready
        base = got.size();
        exp.delete();
        for (int c = 0; c < 400 && got.size() - base < 16; c++) begin
            wr_en = c < 16;
            wr_data = 8'($urandom);
            if (wr_en) exp.push_back(wr_data);
            bus.ready = 1'($urandom_range(0, 1));
            tick();
        end
        wr_en = 1'b0;
        bus.ready = 1'b1;
        cmp_words("t3", base, exp);
        tick();
        tick();
        // single word
        base = got.size();
        rd_base = rd_cnt;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            nv += int'(bus.valid);
            tick();
        end
        check("t4_rdreq_pulses", rd_cnt - rd_base, 1);
        check("t4_valid_cycles", nv, 1);
        check("t4_valid_end", {31'b0, bus.valid}, 0);
        check("t4_rdreq_end", {31'b0, bus.fifo_rdreq}, 0);
        exp = '{8'hA5};
        cmp_words("t4", base, exp);
        // reset in the middle of a stream
        base = got.size();
        for (int c = 0; c < 40 && got.size() - base < 3; c++) begin
            wr_en = c < 8;
            wr_data = 8'(8'h40 + 8'(c));
            tick();
        end
        check("t5_delivered_before_rst", got.size() - base, 3);
        wr_en = 1'b0;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("t5_valid_after_rst", {31'b0, bus.valid}, 0);
        check("t5_used_after_rst", {30'b0, bus.buf_used}, 0);
        check("t5_rdreq_after_rst", {31'b0, bus.fifo_rdreq}, 0);
        base = got.size();
        wr_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        exp = '{8'h5A};
        cmp_words("t5", base, exp);
        // continuous writer and reader
        base = got.size();
        exp.delete();
        nv = 0;
        for (int c = 0; c < 72; c++) begin
            wr_en = c < 64;
            wr_data = 8'(c);
            if (wr_en) exp.push_back(wr_data);
            if (c >= 3 && c <= 63) nv += int'(bus.valid);
            tick();
        end
        wr_en = 1'b0;
        check("t6_valid_steady", nv, 61);
        cmp_words("t6", base, exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
